// File: rtl/ahfp_addsub_pipe.sv
// Pipelined IEEE-style floating-point add/subtract with a latency of 5 enabled cycles.
// Denormal inputs are flushed to zero. Rounding is round-to-nearest-even.
// Special values are handled: NaN, infinity, signed zero, overflow and underflow.
// Ports:
//   clk, reset (synchronous, active-high), clk_en (advance enable for the whole pipe)
//   in_valid, op_sub, dataa, datab        : operation issue (sampled when clk_en=1)
//   out_valid, result                     : registered result with valid tag
//   overflow, underflow, invalid          : per-result exception flags
module ahfp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       in_valid,
    input  logic                       op_sub,
    input  logic [EXP_W+MAN_W:0]       dataa,
    input  logic [EXP_W+MAN_W:0]       datab,
    output logic                       out_valid,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       invalid
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned FW   = MAN_W + 4;          // hidden+frac, G, R, S
    localparam int unsigned SW   = MAN_W + 3;          // hidden+frac, G, R
    localparam int unsigned XW   = EXP_W + 2;          // signed exponent intermediates
    localparam int unsigned LZ_W = $clog2(FW + 1);
    localparam int unsigned EMAX = (1 << EXP_W) - 1;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_NAN  = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_ZERO = 2'd3;

    // S1: unpack, classify, order operands by magnitude
    logic [EXP_W-1:0] ea_c, eb_c;
    logic [MAN_W-1:0] fa_c, fb_c;
    logic             sa_c, sb_c, za_c, zb_c, infa_c, infb_c, nana_c, nanb_c, swap_c;
    logic [W-2:0]     maga_c, magb_c;
    logic [1:0]       kind_c;
    logic             ksign_c;

    always_comb begin
        ea_c    = dataa[W-2 -: EXP_W];
        eb_c    = datab[W-2 -: EXP_W];
        fa_c    = dataa[MAN_W-1:0];
        fb_c    = datab[MAN_W-1:0];
        sa_c    = dataa[W-1];
        sb_c    = datab[W-1] ^ op_sub;
        za_c    = (ea_c == '0);
        zb_c    = (eb_c == '0);
        infa_c  = (ea_c == '1) && (fa_c == '0);
        infb_c  = (eb_c == '1) && (fb_c == '0);
        nana_c  = (ea_c == '1) && (fa_c != '0);
        nanb_c  = (eb_c == '1) && (fb_c != '0);
        maga_c  = za_c ? '0 : dataa[W-2:0];
        magb_c  = zb_c ? '0 : datab[W-2:0];
        swap_c  = (magb_c > maga_c);
        kind_c  = K_NONE;
        ksign_c = 1'b0;
        if (nana_c || nanb_c || (infa_c && infb_c && (sa_c != sb_c))) begin
            kind_c = K_NAN;
        end else if (infa_c || infb_c) begin
            kind_c  = K_INF;
            ksign_c = infa_c ? sa_c : sb_c;
        end else if (za_c && zb_c) begin
            kind_c  = K_ZERO;
            ksign_c = sa_c & sb_c;
        end
    end

    logic             v1;
    logic             s1_sbig, s1_ssml;
    logic [EXP_W-1:0] s1_ebig, s1_esml;
    logic [MAN_W:0]   s1_mbig, s1_msml;
    logic [1:0]       s1_kind;
    logic             s1_ksign;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
        end else if (clk_en) begin
            v1       <= in_valid;
            s1_kind  <= kind_c;
            s1_ksign <= ksign_c;
            s1_sbig  <= swap_c ? sb_c : sa_c;
            s1_ssml  <= swap_c ? sa_c : sb_c;
            s1_ebig  <= swap_c ? eb_c : ea_c;
            s1_esml  <= swap_c ? ea_c : eb_c;
            s1_mbig  <= swap_c ? (zb_c ? '0 : {1'b1, fb_c}) : (za_c ? '0 : {1'b1, fa_c});
            s1_msml  <= swap_c ? (za_c ? '0 : {1'b1, fa_c}) : (zb_c ? '0 : {1'b1, fb_c});
        end
    end

    // S2: align small operand; distances beyond the G/R window land wholly in sticky
    logic [EXP_W-1:0] diff_c, shamt_c;
    logic [2*SW-1:0]  wide_c;

    always_comb begin
        diff_c  = s1_ebig - s1_esml;
        shamt_c = (diff_c > EXP_W'(SW)) ? EXP_W'(SW) : diff_c;
        wide_c  = {s1_msml, 2'b00, {SW{1'b0}}} >> shamt_c;
    end

    logic             v2, s2_sign, s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [FW-1:0]    s2_big, s2_sml;
    logic [1:0]       s2_kind;
    logic             s2_ksign;

    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
        end else if (clk_en) begin
            v2       <= v1;
            s2_sign  <= s1_sbig;
            s2_sub   <= s1_sbig ^ s1_ssml;
            s2_exp   <= s1_ebig;
            s2_big   <= {s1_mbig, 3'b000};
            s2_sml   <= {wide_c[2*SW-1:SW], |wide_c[SW-1:0]};
            s2_kind  <= s1_kind;
            s2_ksign <= s1_ksign;
        end
    end

    // S3: magnitude add or subtract (big >= small, so never negative)
    logic          v3, s3_sign;
    logic [XW-1:0] s3_exp;
    logic [FW:0]   s3_mag;
    logic [1:0]    s3_kind;
    logic          s3_ksign;

    always_ff @(posedge clk) begin
        if (reset) begin
            v3 <= 1'b0;
        end else if (clk_en) begin
            v3       <= v2;
            s3_sign  <= s2_sign;
            s3_exp   <= XW'(s2_exp);
            s3_mag   <= s2_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                               : ({1'b0, s2_big} + {1'b0, s2_sml});
            s3_kind  <= s2_kind;
            s3_ksign <= s2_ksign;
        end
    end

    // S4: normalise on carry-out or by leading-zero count
    logic [LZ_W-1:0] lzc_c;
    logic [FW-1:0]   norm_c;
    logic [XW-1:0]   nexp_c;

    always_comb begin
        lzc_c = LZ_W'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (s3_mag[i]) lzc_c = LZ_W'(int'(FW) - 1 - i);
        end
        if (s3_mag[FW]) begin
            norm_c = {s3_mag[FW:2], s3_mag[1] | s3_mag[0]};
            nexp_c = s3_exp + XW'(1);
        end else begin
            norm_c = s3_mag[FW-1:0] << lzc_c;
            nexp_c = s3_exp - XW'(lzc_c);
        end
    end

    logic          v4, s4_sign, s4_zero;
    logic [XW-1:0] s4_exp;
    logic [FW-1:0] s4_norm;
    logic [1:0]    s4_kind;
    logic          s4_ksign;

    always_ff @(posedge clk) begin
        if (reset) begin
            v4 <= 1'b0;
        end else if (clk_en) begin
            v4       <= v3;
            s4_sign  <= s3_sign;
            s4_zero  <= (s3_mag == '0);
            s4_exp   <= nexp_c;
            s4_norm  <= norm_c;
            s4_kind  <= s3_kind;
            s4_ksign <= s3_ksign;
        end
    end

    // S5: round to nearest even, then pack with special-case priority
    logic             inc_c;
    logic [MAN_W+1:0] mrnd_c;
    logic [XW-1:0]    rexp_c;
    logic [MAN_W-1:0] frac_c;
    logic [W-1:0]     res_c;
    logic             ovf_c, unf_c, inv_c;

    always_comb begin
        inc_c  = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
        mrnd_c = {1'b0, s4_norm[FW-1:3]} + (MAN_W+2)'(inc_c);
        rexp_c = mrnd_c[MAN_W+1] ? (s4_exp + XW'(1)) : s4_exp;
        frac_c = mrnd_c[MAN_W+1] ? '0 : mrnd_c[MAN_W-1:0];
        res_c  = {s4_sign, rexp_c[EXP_W-1:0], frac_c};
        ovf_c  = 1'b0;
        unf_c  = 1'b0;
        inv_c  = 1'b0;
        if (s4_kind == K_NAN) begin
            res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            inv_c = 1'b1;
        end else if (s4_kind == K_INF) begin
            res_c = {s4_ksign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s4_kind == K_ZERO) begin
            res_c = {s4_ksign, {(W-1){1'b0}}};
        end else if (s4_zero) begin
            res_c = '0;
        end else if (!rexp_c[XW-1] && (rexp_c >= XW'(EMAX))) begin
            res_c = {s4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
        end else if (rexp_c[XW-1] || (rexp_c == '0)) begin
            res_c = {s4_sign, {(W-1){1'b0}}};
            unf_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (clk_en) begin
            out_valid <= v4;
            if (v4) begin
                result    <= res_c;
                overflow  <= ovf_c;
                underflow <= unf_c;
                invalid   <= inv_c;
            end
        end
    end

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Scoreboard bench for ahfp_addsub_pipe (FP32): directed vectors with hand-computed results.
module tb_ahfp_addsub_pipe;
    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        reset, clk_en, in_valid, op_sub;
    logic [31:0] dataa, datab;
    logic        out_valid, overflow, underflow, invalid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    // expected: {result, overflow, underflow, invalid}
    logic [34:0] exp_q [$];

    logic [31:0] va  [NV] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h80000000,
                              32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000,
                              32'h00800000, 32'h00000001, 32'h3F800000, 32'h7FC12345,
                              32'h40400000, 32'hBF800000};
    logic [31:0] vb  [NV] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                              32'h33800000, 32'h34400000, 32'h7F7FFFFF, 32'h7F800000,
                              32'h00800001, 32'h3F800000, 32'hFF800000, 32'h3F800000,
                              32'hBF800000, 32'hBF800000};
    logic        vs  [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vr  [NV] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h80000000,
                              32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
                              32'h80000000, 32'h3F800000, 32'hFF800000, 32'h7FC00000,
                              32'h40000000, 32'h00000000};
    logic [2:0]  vf  [NV] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001,
                              3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};

    ahfp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .op_sub    (op_sub),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic issue(input int i);
        @(negedge clk);
        clk_en   = 1'b1;
        in_valid = 1'b1;
        dataa    = va[i];
        datab    = vb[i];
        op_sub   = vs[i];
        exp_q.push_back({vr[i], vf[i]});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            clk_en   = 1'b1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: compare each presented result against the scoreboard head
    always @(posedge clk) begin
        logic        en_s;
        logic [34:0] e;
        en_s = clk_en && !reset;
        #1;
        if (en_s && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
            end else begin
                e = exp_q.pop_front();
                if ({result, overflow, underflow, invalid} !== e) begin
                    errors++;
                    $display("FAIL result: got %h ov%b un%b inv%b required %h ov%b un%b inv%b",
                             result, overflow, underflow, invalid, e[34:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; op_sub = 1'b0;
        dataa = '0; datab = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'({overflow, underflow, invalid}), 32'd0);
        reset = 1'b0;

        // Back-to-back stream with a 3-cycle clk_en stall in the middle
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                @(negedge clk);
                clk_en = 1'b0; in_valid = 1'b1;
                dataa = va[4]; datab = vb[4]; op_sub = vs[4];
                repeat (2) @(negedge clk);
            end
            issue(i);
        end
        idle(1);
        drain();

        // Remaining vectors with bubbles between some issues
        for (int i = 8; i < NV; i++) begin
            issue(i);
            if (i % 2 == 0) idle(1);
        end
        idle(1);
        drain();

        // Reset with three operations in flight
        issue(0); issue(1); issue(2);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
        end
        issue(5);
        idle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
